// File: rtl/enable_div_gen.sv
// Programmable clock-enable divider: one-cycle o_en strobe every N i_ce cycles, periodic or one-shot.
// Zero latency: o_en/o_busy are combinational from registers and i_ce; no backpressure, i_ce only gates counting.
module enable_div_gen #(
    parameter int WIDTH       = 4,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_sclr,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_div,
    input  logic             i_load,
    input  logic             i_oneshot,
    input  logic             i_start,
    output logic             o_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_busy,
    output logic             o_div_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             err_q, err_d;

    logic             wrap;
    logic             apply;
    logic [WIDTH-1:0] apply_val;
    logic             apply_zero;

    assign wrap       = (state_q == RUN) && i_ce && (cnt_q == div_q - ONE);
    assign apply      = i_sclr || wrap || (state_q == IDLE);
    // A load on an apply point bypasses the stale shadow value.
    assign apply_val  = i_load ? i_div : pend_q;
    assign apply_zero = (apply_val == '0);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_sclr) begin
            state_d = i_oneshot ? IDLE : RUN;
        end else begin
            case (state_q)
                IDLE:    if (!i_oneshot || i_start) state_d = RUN;
                RUN:     if (wrap && i_oneshot) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy    = (state_q == RUN);
        o_en      = (state_q == RUN) && i_ce && (cnt_q == '0);
        o_cnt     = cnt_q;
        o_div_err = err_q;
    end

    always_comb begin
        pend_d = i_load ? i_div : pend_q;
        div_d  = div_q;
        if (apply) begin
            div_d = apply_zero ? ONE : apply_val;
        end
        err_d = (err_q && !i_sclr) || (apply && apply_zero);

        cnt_d = cnt_q;
        if (i_sclr || (state_q == IDLE)) begin
            cnt_d = '0;
        end else if (i_ce) begin
            cnt_d = wrap ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            div_q  <= DEF_DIV;
            pend_q <= DEF_DIV;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_enable_div_gen.sv
// Directed bench for enable_div_gen: stimulus pushes hand-derived per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_enable_div_gen;

    logic       clk = 1'b0;
    logic       t_rst_n = 1'b0;
    logic       t_sclr = 1'b0;
    logic       t_ce = 1'b1;
    logic [3:0] t_div = 4'd0;
    logic       t_load = 1'b0;
    logic       t_os = 1'b0;
    logic       t_start = 1'b0;
    logic       o_en;
    logic [3:0] o_cnt;
    logic       o_busy;
    logic       o_div_err;

    logic       c_sclr = 1'b0;
    logic       c_load = 1'b0;
    logic [3:0] a_div = 4'd3;
    logic [3:0] b_div = 4'd4;
    logic       a_en, b_en, a_busy, b_busy, a_err, b_err;
    logic [3:0] a_cnt, b_cnt;

    always #5 clk = ~clk;

    enable_div_gen #(.WIDTH(4), .DEFAULT_DIV(10)) dut (
        .clk(clk), .i_rst_n(t_rst_n), .i_sclr(t_sclr), .i_ce(t_ce), .i_div(t_div),
        .i_load(t_load), .i_oneshot(t_os), .i_start(t_start),
        .o_en(o_en), .o_cnt(o_cnt), .o_busy(o_busy), .o_div_err(o_div_err)
    );

    enable_div_gen #(.WIDTH(4), .DEFAULT_DIV(10)) u_a (
        .clk(clk), .i_rst_n(t_rst_n), .i_sclr(c_sclr), .i_ce(1'b1), .i_div(a_div),
        .i_load(c_load), .i_oneshot(1'b0), .i_start(1'b0),
        .o_en(a_en), .o_cnt(a_cnt), .o_busy(a_busy), .o_div_err(a_err)
    );

    enable_div_gen #(.WIDTH(4), .DEFAULT_DIV(10)) u_b (
        .clk(clk), .i_rst_n(t_rst_n), .i_sclr(c_sclr), .i_ce(a_en), .i_div(b_div),
        .i_load(c_load), .i_oneshot(1'b0), .i_start(1'b0),
        .o_en(b_en), .o_cnt(b_cnt), .o_busy(b_busy), .o_div_err(b_err)
    );

    typedef struct packed {
        logic        kind;   // 0: main DUT, 1: cascade stage-B strobe
        logic        en;
        logic [3:0]  cnt;
        logic        busy;
        logic        err;
        logic [63:0] tag;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                vectors++;
                if (e.kind) begin
                    if (b_en !== e.en) begin
                        miscompares++;
                        $display("FAIL %s: b_en=%b required %b", e.tag, b_en, e.en);
                    end
                end else if ({o_en, o_cnt, o_busy, o_div_err} !== {e.en, e.cnt, e.busy, e.err}) begin
                    miscompares++;
                    $display("FAIL %s: en/cnt/busy/err=%b/%0d/%b/%b required %b/%0d/%b/%b",
                             e.tag, o_en, o_cnt, o_busy, o_div_err, e.en, e.cnt, e.busy, e.err);
                end
            end
        end
    end

    task automatic cyc(input logic rst, input logic ce, input logic sclr, input logic load,
                       input logic [3:0] div, input logic os, input logic st,
                       input logic x_en, input logic [3:0] x_cnt, input logic x_busy,
                       input logic x_err, input logic [63:0] tag);
        exp_t e;
        @(posedge clk);
        #1;
        t_rst_n = rst; t_ce = ce; t_sclr = sclr; t_load = load;
        t_div = div; t_os = os; t_start = st;
        e = '{kind: 1'b0, en: x_en, cnt: x_cnt, busy: x_busy, err: x_err, tag: tag};
        sb.push_back(e);
    endtask

    task automatic ccyc(input logic s, input logic chk, input logic x_en, input logic [63:0] tag);
        exp_t e;
        @(posedge clk);
        #1;
        c_sclr = s; c_load = s;
        if (chk) begin
            e = '{kind: 1'b1, en: x_en, cnt: 4'd0, busy: 1'b0, err: 1'b0, tag: tag};
            sb.push_back(e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and release: one IDLE cycle, then periodic RUN with default ratio 10.
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "release");
        for (int k = 0; k < 5; k++) cyc(1, 1, 0, 0, 0, 0, 0, k == 0, 4'(k), 1, 0, "p_rst");
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 5, 1, 0, "sclr");
        for (int k = 0; k < 30; k++) cyc(1, 1, 0, 0, 0, 0, 0, (k % 10) == 0, 4'(k % 10), 1, 0, "period");

        // Reload to 3 mid-period: old period finishes at cnt 9.
        for (int k = 0; k < 4; k++) cyc(1, 1, 0, 0, 0, 0, 0, k == 0, 4'(k), 1, 0, "reload");
        cyc(1, 1, 0, 1, 3, 0, 0, 0, 4, 1, 0, "ld_at4");
        for (int k = 5; k < 10; k++) cyc(1, 1, 0, 0, 3, 0, 0, 0, 4'(k), 1, 0, "old_per");
        for (int k = 0; k < 9; k++) cyc(1, 1, 0, 0, 3, 0, 0, (k % 3) == 0, 4'(k % 3), 1, 0, "div3");

        // Zero divisor: ratio 1 and sticky error until sclr.
        cyc(1, 1, 0, 0, 3, 0, 0, 1, 0, 1, 0, "div3");
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, "ld_zero");
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 2, 1, 0, "z_wrap");
        for (int k = 0; k < 4; k++) cyc(1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, "div0");
        cyc(1, 1, 1, 1, 10, 0, 0, 1, 0, 1, 1, "sclr_err");

        // CE gated 1-of-2 with ratio 10: strobe every 20 clocks, cnt frozen on ce=0.
        for (int k = 0; k < 40; k++)
            cyc(1, (k % 2) == 0, 0, 0, 10, 0, 0, (k % 20) == 0, 4'(((k + 1) / 2) % 10), 1, 0, "ce_gate");

        // Mid-period async reset drops outputs at once and discards a pending load.
        for (int k = 0; k < 6; k++) cyc(1, 1, 0, k == 2, 3, 0, 0, k == 0, 4'(k), 1, 0, "pre_rst");
        cyc(0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, "async_rst");
        cyc(0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, "in_rst");
        cyc(1, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, "release2");
        for (int k = 0; k < 11; k++) cyc(1, 1, 0, 0, 3, 0, 0, (k % 10) == 0, 4'(k % 10), 1, 0, "post_rst");

        // sclr coinciding with wrap and start: single strobe, restart at 0.
        for (int k = 1; k < 9; k++) cyc(1, 1, 0, 0, 3, 0, 0, 0, 4'(k), 1, 0, "to_wrap");
        cyc(1, 1, 1, 0, 3, 0, 1, 0, 9, 1, 0, "sclr_wrap");
        cyc(1, 1, 0, 0, 3, 0, 0, 1, 0, 1, 0, "sclr_nxt");
        cyc(1, 1, 0, 0, 3, 0, 0, 0, 1, 1, 0, "no_dbl");

        // One-shot with ratio 5.
        cyc(1, 1, 1, 1, 5, 1, 0, 0, 2, 1, 0, "os_entry");
        for (int k = 0; k < 2; k++) cyc(1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, "os_idle");
        cyc(1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, "os_start");
        for (int k = 0; k < 5; k++) cyc(1, 1, 0, 0, 5, 1, k == 2, k == 0, 4'(k), 1, 0, "os_run");
        for (int k = 0; k < 2; k++) cyc(1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, "os_done");
        cyc(1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, "os_retrig");
        for (int k = 0; k < 5; k++) cyc(1, 1, 0, 0, 5, 1, k == 4, k == 0, 4'(k), 1, 0, "os_run2");
        for (int k = 0; k < 2; k++) cyc(1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, "os_term");
        cyc(1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, "os_st3");
        for (int k = 0; k < 4; k++) cyc(1, 1, 0, 0, 5, 1, 0, k == 0, 4'(k), 1, 0, "os_run3");
        cyc(1, 1, 1, 0, 5, 1, 1, 0, 4, 1, 0, "os_sclr");
        for (int k = 0; k < 2; k++) cyc(1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, "os_sclr_i");

        // Cascade 3 x 4: stage-B strobe every 12 clocks.
        ccyc(1, 0, 0, "casc");
        for (int k = 0; k < 36; k++) ccyc(0, 1, (k % 12) == 0, "casc");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
